// File: rtl/zombie_pkg.sv
// zombie_spawner shared types: FSM states, lane codes, LFSR constants.
// Optional feature macro: ZOMBIE_NO_REPEAT_EN (used in zombie_spawner.sv).
package zombie_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PICK = 2'd1,
      SHOW = 2'd2
   } state_t;

   typedef logic [1:0] lane_t;

   localparam lane_t LANE1     = 2'b00;
   localparam lane_t LANE2     = 2'b01;
   localparam lane_t LANE3     = 2'b10;
   localparam lane_t LANE_NONE = 2'b11;

   // taps 16,14,13,11 -> state bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic logic [2:0] lane_onehot(input lane_t l);
      logic [2:0] oh;
      oh = 3'b000;
      case (l)
         LANE1:   oh = 3'b001;
         LANE2:   oh = 3'b010;
         LANE3:   oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/zombie_lfsr.sv
// Free-running 16-bit Fibonacci LFSR for lane selection.
// A zero seed is replaced by the default seed so the LFSR never locks up.
module zombie_lfsr
   import zombie_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   localparam logic [15:0] LOAD =
      (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // shift left, feedback is the parity of the tapped bits
   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // state register, reloads the seed on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LOAD;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/zombie_spawner.sv
// PunchZombi spawner: picks a lane, shows it, counts hits and misses.
// Macro ZOMBIE_NO_REPEAT_EN: forbid the same lane twice in a row.
module zombie_spawner
   import zombie_pkg::*;
#(
   parameter logic [15:0]        LFSR_SEED   = LFSR_DEFAULT_SEED,
   parameter int unsigned        TIMER_W     = 24,
   parameter logic [TIMER_W-1:0] HOLD_CYCLES = 24'd12_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       need_random,
   input  logic       shift,
   output logic       MD1,
   output logic       MD2,
   output logic       MD3,
   output logic [7:0] hit_count,
   output logic [7:0] miss_count
);

   localparam logic [TIMER_W-1:0] HOLD_LAST = HOLD_CYCLES - 1'b1;

   logic [15:0] lfsr_state;
   logic [13:0] lfsr_unused;
   lane_t       cand;
   logic        cand_ok;

   state_t             state_q, state_d;
   lane_t              lane_q, lane_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         md_q, md_d;
   logic [7:0]         hit_q, hit_d;
   logic [7:0]         miss_q, miss_d;

   zombie_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr_state)
   );

   assign cand        = lfsr_state[1:0];
   assign lfsr_unused = lfsr_state[15:2];

`ifdef ZOMBIE_NO_REPEAT_EN
   // lane_q doubles as the previous lane; it resets to LANE_NONE
   assign cand_ok = (cand != LANE_NONE) && (cand != lane_q);
`else
   assign cand_ok = (cand != LANE_NONE);
`endif

   // next-state, timer, lane and counter logic
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      timer_d = timer_q;
      md_d    = md_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      unique case (state_q)
         IDLE: begin
            md_d = 3'b000;
            if (need_random) begin
               state_d = PICK;
            end
         end
         PICK: begin
            md_d = 3'b000;
            if (cand_ok) begin
               lane_d  = cand;
               timer_d = '0;
               md_d    = lane_onehot(cand);
               state_d = SHOW;
            end
         end
         SHOW: begin
            timer_d = timer_q + 1'b1;
            if (shift) begin
               if (hit_q != 8'hFF) begin
                  hit_d = hit_q + 8'd1;
               end
               md_d    = 3'b000;
               state_d = PICK;
            end else if (timer_q == HOLD_LAST) begin
               if (miss_q != 8'hFF) begin
                  miss_d = miss_q + 8'd1;
               end
               md_d    = 3'b000;
               state_d = PICK;
            end
         end
         default: begin
            md_d    = 3'b000;
            state_d = IDLE;
         end
      endcase
   end

   // FSM and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= LANE_NONE;
         timer_q <= '0;
         md_q    <= 3'b000;
         hit_q   <= 8'd0;
         miss_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         timer_q <= timer_d;
         md_q    <= md_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   assign MD1        = md_q[0];
   assign MD2        = md_q[1];
   assign MD3        = md_q[2];
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_zombie_spawner.sv
// Directed self-checking bench for zombie_spawner (HOLD_CYCLES = 8).
// Expected counts go through a scoreboard queue; lanes come from an LFSR model.
module tb_zombie_spawner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       need_random = 1'b1;
   logic       shift = 1'b0;
   logic       md1, md2, md3;
   logic [7:0] hit_count, miss_count;
   logic [2:0] md_v;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   logic [15:0] m_lfsr;
   logic [1:0]  last_cand;
   logic [2:0]  first_lane, lane, prev_lane;

   zombie_spawner #(
      .LFSR_SEED   (16'hACE1),
      .TIMER_W     (24),
      .HOLD_CYCLES (24'd8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .need_random (need_random),
      .shift       (shift),
      .MD1         (md1),
      .MD2         (md2),
      .MD3         (md3),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   assign md_v = {md3, md2, md1};

   always #5 clk = ~clk;

   // reference LFSR, taps 16,14,13,11; last_cand is the value seen at the last edge
   always @(posedge clk) begin
      last_cand <= m_lfsr[1:0];
      if (rst) m_lfsr <= 16'hACE1;
      else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_lane(input string tag, output logic [2:0] l);
      int n;
      n = 0;
      while (md_v == 3'b000 && n < 17) begin
         step();
         n++;
      end
      check({tag, "_bound"}, 32'(md_v != 3'b000 && n <= 16), 1);
      check({tag, "_onehot"}, 32'($onehot(md_v)), 1);
      check({tag, "_lane"}, md_v, 3'b001 << last_cand);
      l = md_v;
   endtask

   task automatic reset_start();
      rst = 1'b1;
      need_random = 1'b1;
      shift = 1'b0;
      repeat (3) begin
         step();
         check("rst_md", md_v, 0);
         check("rst_hit", hit_count, 0);
         check("rst_miss", miss_count, 0);
      end
      rst = 1'b0;
      need_random = 1'b0;
      repeat (4) begin
         step();
         check("idle_md", md_v, 0);
      end
      need_random = 1'b1;
      step();
      need_random = 1'b0;
      check("pick_md", md_v, 0);
   endtask

   task automatic do_hit(input int exp_hit, input int exp_miss);
      int e;
      shift = 1'b1;
      exp_q.push_back(sat(exp_hit));
      step();
      shift = 1'b0;
      e = exp_q.pop_front();
      check("hit_cnt", hit_count, e);
      check("hit_md", md_v, 0);
      check("hit_miss", miss_count, exp_miss);
   endtask

   task automatic do_miss(input int exp_miss, input int exp_hit);
      int cnt, e;
      cnt = 0;
      exp_q.push_back(sat(exp_miss));
      while (md_v != 3'b000 && cnt < 20) begin
         step();
         cnt++;
      end
      e = exp_q.pop_front();
      check("miss_len", cnt, 8);
      check("miss_cnt", miss_count, e);
      check("miss_hit", hit_count, exp_hit);
   endtask

   initial begin
      // power-on reset and first spawn
      reset_start();
      wait_lane("start", first_lane);
      repeat (5) begin
         step();
         check("stable", md_v, first_lane);
      end

      // hits up to saturation
      for (int i = 1; i <= 300; i++) begin
         do_hit(i, 0);
         wait_lane("hit", lane);
      end
      check("hit_sat", hit_count, 255);

      // reset in the middle of SHOW, restart matches power-on lane
      check("pre_rst_md", 32'(md_v != 3'b000), 1);
      reset_start();
      wait_lane("restart", lane);
      check("restart_lane", lane, first_lane);

      // one plain miss
      do_miss(1, 0);
      wait_lane("miss", lane);

      // shift on the timeout cycle: hit wins
      repeat (7) step();
      check("coll_md", md_v, lane);
      do_hit(1, 1);
      wait_lane("coll", lane);

      // misses up to saturation
      for (int i = 2; i <= 301; i++) begin
         do_miss(i, 1);
         wait_lane("miss", lane);
      end
      check("miss_sat", miss_count, 255);

`ifdef ZOMBIE_NO_REPEAT_EN
      prev_lane = lane;
      for (int i = 0; i < 1000; i++) begin
         do_hit(2 + i, 255);
         wait_lane("nr", lane);
         check("no_repeat", 32'(lane != prev_lane), 1);
         prev_lane = lane;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/zombie_spawner.md
# zombie_spawner

Downstream consumer of the hit detector in the PunchZombi game. Turns the detector's `need_random`/`shift` strobes into the next zombie position. Picks one of three lanes with a free-running LFSR, shows it one-hot on `MD1`..`MD3` for a bounded time, and counts hits and misses. Its `MD1`..`MD3` outputs feed the detector's inputs of the same names, closing the game loop.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR load value on reset. A value of 0 is replaced by 16'hACE1.
- `TIMER_W`, default 24: width of the show-time counter.
- `HOLD_CYCLES`, default 24'd12_000_000: cycles a zombie stays up before it counts as a miss. Legal range is ≥ 2.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `need_random` in 1: start/respawn request from the detector, level sampled each `clk`.
- `shift` in 1: hit strobe from the detector, level sampled each `clk`.
- `MD1`, `MD2`, `MD3` out 1 each: zombie present in lane 1/2/3. At most one is high.
- `hit_count` out 8: saturating hit counter.
- `miss_count` out 8: saturating miss counter.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every cycle, in every state.
  - Candidate lane = `lfsr[1:0]`: 00→lane1, 01→lane2, 10→lane3, 11→invalid.
- **State IDLE** (reset state)
  - `MD` = 000.
  - `need_random`=1 → PICK.
- **State PICK**
  - `MD` = 000.
  - Candidate valid → latch lane, clear timer, go to SHOW.
  - Candidate invalid → stay in PICK and retry next cycle.
- **State SHOW**
  - The latched lane's `MD` is high.
  - Timer increments by 1 per cycle from 0.
  - `shift`=1 → `hit_count`+1 (saturates at 255), go to PICK.
  - Else, timer == `HOLD_CYCLES`-1 → `miss_count`+1 (saturates at 255), go to PICK.
  - `need_random` without `shift` in SHOW is ignored.
- **Boundary cases**
  - `shift` and timeout in the same cycle → hit wins; `miss_count` unchanged.
  - `need_random`/`shift` in PICK → ignored.
  - `shift` in IDLE → ignored.
  - Counter at 255 → holds at 255; no wrap.
  - `rst` at any time → IDLE on the next edge; all outputs at their reset values; LFSR reloads its seed.

## Timing
- Reset values: `MD1`=`MD2`=`MD3`=0, `hit_count`=0, `miss_count`=0, state IDLE, timer 0, LFSR = `LFSR_SEED` (or 16'hACE1 if the seed is 0).
- All outputs are registered.
- `need_random` high at edge N (state IDLE) → PICK at N+1 → `MD` one-hot at N+2 at the earliest. Each invalid candidate adds one cycle.
- `shift` high at edge N in SHOW:
  - `hit_count` updated and `MD`=000 at N+1.
  - New lane at N+2 at the earliest.
- Timeout: `MD` stays high for exactly `HOLD_CYCLES` cycles, then drops to 000 in the same cycle `miss_count` updates.
- Maximum run of consecutive invalid candidates from a maximal-length LFSR is bounded. The bench treats more than 16 cycles in PICK as a failure.

## Configuration
- Macro: `ZOMBIE_NO_REPEAT_EN`.
- **Defined:**
  - In PICK, a candidate equal to the previous lane is also treated as invalid, so consecutive zombies are always in different lanes.
  - The previous-lane register resets to "none", so the first pick is unrestricted.
- **Undefined:**
  - Only 11 is rejected.
  - The same lane may repeat.
  - No previous-lane register is built.

## Structure
- Package `zombie_pkg` holds:
  - state enum (IDLE, PICK, SHOW);
  - lane encoding constants (LANE1/LANE2/LANE3/LANE_NONE);
  - LFSR tap constant;
  - default seed 16'hACE1.
- One sub-module, `zombie_lfsr`:
  - ports `clk`, `rst`, seed parameter, 16-bit state output;
  - advances every cycle;
  - zero-seed substitution is done inside it.
- FSM, show timer and counters live in `zombie_spawner`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `need_random`=1 → `MD`=000, both counts 0, state IDLE after release until the next `need_random`.
- **Start:** `HOLD_CYCLES`=8; pulse `need_random` 1 cycle → exactly one `MD` high within 2–16 cycles; `MD` stays stable while `shift`=0.
- **Hit:** in SHOW, pulse `shift` 1 cycle → `hit_count`=1 and `MD`=000 on the next cycle; a new one-hot lane within 16 cycles. Repeat 300 times → `hit_count` = 255, with no wrap.
- **Miss:** `HOLD_CYCLES`=8, never assert `shift` → `MD` high for exactly 8 cycles; `miss_count` increments every time; 300 misses → 255.
- **Collision:** assert `shift` in the cycle where timer = 7 → `hit_count`+1 and `miss_count` unchanged.
- **No-repeat and mid-run reset:** with `ZOMBIE_NO_REPEAT_EN`, 1000 hits → no two consecutive lanes equal. Assert `rst` mid-SHOW → `MD`=000 and counts 0 next cycle; the first lane after restart matches the first lane after power-on reset.
